// File: rtl/prefetch_fetch_stage.sv
// Prefetching fetch stage: owns the PC, keeps imem requests in flight
// and buffers returned instructions in a small FIFO ahead of decode.
module prefetch_fetch_stage #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUTST = 2,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus_4
);

   localparam int CW = $clog2(MAX_OUTST + 1);
   localparam int FW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = ((FW > CW) ? FW : CW) + 1;

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW-1:0]   r_outst;
   logic [CW-1:0]   r_drop;
   logic [FW-1:0]   r_count;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [31:0]     r_mem_instr [DEPTH];
   logic [XLEN-1:0] r_mem_pc    [DEPTH];

   logic [CW-1:0]   w_live;
   logic [SW-1:0]   w_occ;
   logic            w_empty;
   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_rsp_fire;
   logic            w_dropping;
   logic            w_push;
   logic            w_instr_valid;
   logic            w_pop;
   logic [XLEN-1:0] w_head_pc;

   // Credit: buffered entries plus responses still owed must fit the FIFO.
   assign w_live        = r_outst - r_drop;
   assign w_occ         = SW'(r_count) + SW'(w_live);
   assign w_empty       = (r_count == '0);
   assign w_req_valid   = !rst && !redirect
                        && (r_outst < CW'(MAX_OUTST))
                        && (w_occ < SW'(DEPTH));
   assign w_req_fire    = w_req_valid && imem_req_ready;
   assign w_rsp_fire    = imem_rsp_valid;
   assign w_dropping    = (r_drop != '0);
   assign w_push        = w_rsp_fire && !w_dropping && !redirect;
   assign w_instr_valid = !w_empty && !redirect;
   assign w_pop         = w_instr_valid && instr_ready;
   assign w_head_pc     = r_mem_pc[r_rd_ptr];

   assign imem_req_valid  = w_req_valid;
   assign imem_req_addr   = r_fetch_pc;
   assign instr_valid     = w_instr_valid;
   assign instr           = w_empty ? '0 : r_mem_instr[r_rd_ptr];
   assign instr_pc        = w_empty ? '0 : w_head_pc;
   assign instr_pc_plus_4 = w_empty ? '0 : w_head_pc + XLEN'(4);

   // Request PC and response PC; a redirect restarts both streams.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= redirect_pc;
         r_rsp_pc   <= redirect_pc;
      end else begin
         if (w_req_fire)
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         if (w_push)
            r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
   end

   // In-flight request count and the number of stale responses to discard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outst <= '0;
         r_drop  <= '0;
      end else begin
         r_outst <= r_outst + CW'(w_req_fire) - CW'(w_rsp_fire);
         if (redirect)
            r_drop <= r_outst - CW'(w_rsp_fire);
         else if (w_rsp_fire && w_dropping)
            r_drop <= r_drop - CW'(1);
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (redirect) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_count <= r_count + FW'(w_push) - FW'(w_pop);
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
      end
   end

   // FIFO storage: instruction paired with the PC it was fetched from.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_instr[i] <= '0;
            r_mem_pc[i]    <= '0;
         end
      end else if (w_push) begin
         r_mem_instr[r_wr_ptr] <= imem_rsp_instr;
         r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
      end
   end

   // The credit check must make a push into a full FIFO impossible.
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!(w_push && (r_count == FW'(DEPTH))));
   end

endmodule

// File: tb/tb_prefetch_fetch_stage.sv
// Bench for prefetch_fetch_stage: randomized imem/decode/redirect
// traffic against a queue-level model, plus directed scenarios.
`timescale 1ns/1ps
module tb_prefetch_fetch_stage;

   localparam int          DEPTH     = 4;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_instr = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus_4;

   always #5 clk = ~clk;

   prefetch_fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_instr  (imem_rsp_instr),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_pc_plus_4 (instr_pc_plus_4)
   );

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          due;
   } req_t;

   // Model: accepted requests awaiting a response, and FIFO contents (PCs).
   req_t        pend[$];
   logic [31:0] fifo_q[$];
   logic [31:0] m_req_pc;

   // Observed DUT handshakes, used by the directed checks.
   logic [31:0] req_log[$];
   logic [31:0] req_cyc[$];
   logic [31:0] pop_log[$];
   logic [31:0] pop_cyc[$];

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int lat_min = 1, lat_max = 1;
   int p_rrdy = 100, p_irdy = 100, p_redir = 0;
   bit          f_redir = 1'b0;
   logic [31:0] f_pc = '0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
   endfunction

   function automatic bit pct(input int p);
      return ($urandom_range(99) < p);
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] v;
      int          sel;
      v   = $urandom();
      sel = $urandom_range(2);
      if (sel == 0) return 32'hFFFF_FFF0 + {28'h0, v[1:0], 2'b00};
      if (sel == 1) return {24'h0, v[7:2], 2'b00};
      return {v[31:2], 2'b00};
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs, compare at negedge, advance model at posedge.
   task automatic cycle();
      int          nlive;
      bit          e_req, e_iv, rv, live_rsp;
      req_t        r, nr;
      logic [31:0] tmp;
      redirect       = f_redir | pct(p_redir);
      redirect_pc    = f_redir ? f_pc : rand_pc();
      f_redir        = 1'b0;
      imem_req_ready = pct(p_rrdy);
      instr_ready    = pct(p_irdy);
      rv             = (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rsp_valid = rv;
      imem_rsp_instr = rv ? mem_f(pend[0].addr) : $urandom();
      @(negedge clk);
      nlive = 0;
      foreach (pend[i]) if (!pend[i].stale) nlive++;
      e_req = !redirect && (pend.size() < MAX_OUTST)
              && (fifo_q.size() + nlive < DEPTH);
      e_iv  = (fifo_q.size() > 0) && !redirect;
      chk("req_valid", 32'(imem_req_valid), 32'(e_req));
      if (e_req) chk("req_addr", imem_req_addr, m_req_pc);
      chk("instr_valid", 32'(instr_valid), 32'(e_iv));
      if (e_iv) begin
         chk("instr", instr, mem_f(fifo_q[0]));
         chk("instr_pc", instr_pc, fifo_q[0]);
         chk("instr_pc_plus_4", instr_pc_plus_4, fifo_q[0] + 32'd4);
      end
      if (imem_req_valid && imem_req_ready) begin
         req_log.push_back(imem_req_addr);
         req_cyc.push_back(32'(cyc));
      end
      if (instr_valid && instr_ready) begin
         pop_log.push_back(instr_pc);
         pop_cyc.push_back(32'(cyc));
      end
      @(posedge clk);
      live_rsp = 1'b0;
      if (rv) begin
         r        = pend.pop_front();
         live_rsp = !r.stale;
      end
      if (redirect) begin
         fifo_q.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         m_req_pc = redirect_pc;
      end else begin
         if (e_iv && instr_ready) tmp = fifo_q.pop_front();
         if (live_rsp) fifo_q.push_back(r.addr);
         if (e_req && imem_req_ready) begin
            nr.addr  = m_req_pc;
            nr.stale = 1'b0;
            nr.due   = cyc + int'($urandom_range(lat_max, lat_min));
            pend.push_back(nr);
            m_req_pc = m_req_pc + 32'd4;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Asynchronous reset in mid-cycle while stale responses are presented.
   task automatic do_reset();
      #2;
      redirect       = 1'b0;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_instr = $urandom();
      rst            = 1'b1;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_instr_pc4", instr_pc_plus_4, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst            = 1'b0;
      imem_rsp_valid = 1'b0;
      pend.delete();
      fifo_q.delete();
      m_req_pc = RESET_PC;
      req_log.delete();
      req_cyc.delete();
      pop_log.delete();
      pop_cyc.delete();
      cyc = 0;
   endtask

   task automatic set_mode(input int lmin, input int lmax, input int rr,
                           input int ir, input int rd);
      lat_min = lmin; lat_max = lmax;
      p_rrdy = rr; p_irdy = ir; p_redir = rd;
   endtask

   initial begin
      int n0;
      m_req_pc = RESET_PC;

      // Streaming with a 1-cycle memory.
      set_mode(1, 1, 100, 100, 0);
      do_reset();
      run(8);
      chk("s1_req0", qget(req_log, 0), 32'h0);
      chk("s1_req1", qget(req_log, 1), 32'h4);
      chk("s1_req2", qget(req_log, 2), 32'h8);
      chk("s1_reqcyc2", qget(req_cyc, 2), 32'd2);
      chk("s1_pop0", qget(pop_log, 0), 32'h0);
      chk("s1_pop1", qget(pop_log, 1), 32'h4);
      chk("s1_pop2", qget(pop_log, 2), 32'h8);
      chk("s1_popcyc0", qget(pop_cyc, 0), 32'd2);
      chk("s1_popcyc2", qget(pop_cyc, 2), 32'd4);

      // Decode stalled: FIFO fills to DEPTH, requests stop, then drains.
      set_mode(1, 1, 100, 0, 0);
      do_reset();
      run(10);
      redirect = 1'b0;
      #1;
      chk("s2_req_valid", 32'(imem_req_valid), 32'd0);
      chk("s2_instr_valid", 32'(instr_valid), 32'd1);
      chk("s2_nreq", 32'(req_log.size()), 32'd4);
      p_irdy = 100;
      run(8);
      chk("s2_pop0", qget(pop_log, 0), 32'h0);
      chk("s2_pop1", qget(pop_log, 1), 32'h4);
      chk("s2_pop2", qget(pop_log, 2), 32'h8);
      chk("s2_pop3", qget(pop_log, 3), 32'hC);

      // 3-cycle memory: two outstanding, third request waits.
      set_mode(3, 3, 100, 100, 0);
      do_reset();
      run(10);
      chk("s3_reqcyc0", qget(req_cyc, 0), 32'd0);
      chk("s3_reqcyc1", qget(req_cyc, 1), 32'd1);
      chk("s3_reqcyc2", qget(req_cyc, 2), 32'd4);

      // Redirect with two requests in flight: both responses dropped.
      set_mode(3, 3, 100, 100, 0);
      do_reset();
      run(2);
      f_redir = 1'b1;
      f_pc    = 32'h100;
      run(12);
      chk("s4_req2", qget(req_log, 2), 32'h100);
      chk("s4_reqcyc2", qget(req_cyc, 2), 32'd4);
      chk("s4_pop0", qget(pop_log, 0), 32'h100);
      chk("s4_pop1", qget(pop_log, 1), 32'h104);

      // Redirect coinciding with a response and a pop.
      set_mode(1, 1, 100, 100, 0);
      do_reset();
      run(6);
      f_redir = 1'b1;
      f_pc    = 32'h200;
      run(1);
      redirect = 1'b0;
      #1;
      chk("s5_instr_valid", 32'(instr_valid), 32'd0);
      chk("s5_req_valid", 32'(imem_req_valid), 32'd1);
      chk("s5_req_addr", imem_req_addr, 32'h200);
      n0 = pop_log.size();
      chk("s5_npop", 32'(n0), 32'd4);
      run(4);
      chk("s5_pop_after", qget(pop_log, n0), 32'h200);

      // Randomized traffic with mid-stream resets.
      for (int rnd = 0; rnd < 20; rnd++) begin
         set_mode(1, int'($urandom_range(4, 1)), int'($urandom_range(100, 30)),
                  int'($urandom_range(100, 20)), int'($urandom_range(8, 0)));
         run(150);
         p_irdy = 10;
         p_redir = 0;
         for (int k = 0; k < 50 && fifo_q.size() < 2; k++) cycle();
         do_reset();
         set_mode(1, 2, 100, 100, 0);
         run(3);
         chk("rst_first_req", qget(req_log, 0), RESET_PC);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
